// File: rtl/uart_rx_core.sv
// uart_rx_core: 16x-oversampled 8N1 UART receiver with valid/ready holding register.
// Ports: clk_i, rst_i, baud_div_i, rx_en_i, rx_i -> data_o, valid_o, ready_i, frame_err_o, overrun_o, busy_o.
module uart_rx_core #(
    parameter int DATA_WIDTH = 8,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [DIV_WIDTH-1:0]  baud_div_i,
    input  logic                  rx_en_i,
    input  logic                  rx_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic                  frame_err_o,
    output logic                  overrun_o,
    output logic                  busy_o
);

    localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BRK
    } state_t;

    state_t state, state_n;

    logic [1:0]            sync;
    logic                  rx_s;
    logic [1:0]            fill;
    logic                  armed;
    logic [DIV_WIDTH-1:0]  div_cnt;
    logic [DIV_WIDTH-1:0]  div_last;
    logic                  tick;
    logic [3:0]            tick_cnt;
    logic                  mid_tick;
    logic                  bit_tick;
    logic [IW-1:0]         bit_idx;
    logic                  last_bit;
    logic [DATA_WIDTH-1:0] shift;
    logic                  deliver;
    logic                  ferr;

    assign rx_s     = sync[1];
    assign div_last = (baud_div_i == '0) ? '0 : baud_div_i - 1'b1;
    // >= so a divisor shrunk mid-frame still wraps at the next opportunity
    assign tick     = (state != IDLE) && (div_cnt >= div_last);
    assign mid_tick = tick && (tick_cnt == 4'd7);
    assign bit_tick = tick && (tick_cnt == 4'd15);
    assign last_bit = (bit_idx == IW'(DATA_WIDTH - 1));
    assign busy_o   = (state != IDLE);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        deliver = 1'b0;
        ferr    = 1'b0;
        unique case (state)
            IDLE: begin
                if (rx_en_i && armed && !rx_s) state_n = START;
            end
            START: begin
                if (mid_tick) state_n = rx_s ? IDLE : DATA;
            end
            DATA: begin
                if (bit_tick && last_bit) state_n = STOP;
            end
            STOP: begin
                if (bit_tick) begin
                    if (rx_s) begin
                        deliver = 1'b1;
                        state_n = IDLE;
                    end else begin
                        ferr    = 1'b1;
                        state_n = BRK;
                    end
                end
            end
            BRK: begin
                if (rx_s) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        if ((state != IDLE) && !rx_en_i) begin
            state_n = IDLE;
            deliver = 1'b0;
            ferr    = 1'b0;
        end
    end

    // armed blocks a line that is already low (after reset or a break)
    // from being taken as a start bit until it has been seen high.
    // fill marks when the synchroniser holds real line samples.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync  <= 2'b11;
            fill  <= 2'b00;
            armed <= 1'b0;
        end else begin
            sync <= {sync[0], rx_i};
            fill <= {fill[0], 1'b1};
            if (state_n == BRK) begin
                armed <= 1'b0;
            end else if (fill[1] && rx_s) begin
                armed <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            div_cnt  <= '0;
            tick_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
        end else begin
            if ((state == IDLE) || (state_n == IDLE) || tick) begin
                div_cnt <= '0;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
            if (state != state_n) begin
                tick_cnt <= '0;
            end else if (tick) begin
                tick_cnt <= tick_cnt + 4'd1;
            end
            if (state != DATA) begin
                bit_idx <= '0;
            end else if (bit_tick) begin
                bit_idx <= bit_idx + 1'b1;
                shift   <= {rx_s, shift[DATA_WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_o      <= '0;
            valid_o     <= 1'b0;
            frame_err_o <= 1'b0;
            overrun_o   <= 1'b0;
        end else begin
            frame_err_o <= ferr;
            overrun_o   <= deliver && valid_o && !ready_i;
            if (deliver) begin
                if (!valid_o || ready_i) begin
                    data_o  <= shift;
                    valid_o <= 1'b1;
                end
            end else if (ready_i) begin
                valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: self-checking bench for uart_rx_core.
// Drives 8N1 frames from a TX model and checks bytes, errors and busy timing.
module tb_uart_rx_core;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] div = 16'd4;
    logic        rx_en = 1'b1;
    logic        rx = 1'b1;
    logic        ready = 1'b1;
    logic [7:0]  data_o;
    logic        valid_o;
    logic        frame_err_o;
    logic        overrun_o;
    logic        busy_o;

    uart_rx_core dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .baud_div_i  (div),
        .rx_en_i     (rx_en),
        .rx_i        (rx),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .ready_i     (ready),
        .frame_err_o (frame_err_o),
        .overrun_o   (overrun_o),
        .busy_o      (busy_o)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    int ferr_cnt, ovr_cnt, vhigh_cnt, busy_cnt;

    always @(negedge clk) begin
        if (!rst) begin
            if (valid_o && ready) got_q.push_back(data_o);
            if (valid_o) vhigh_cnt++;
            if (frame_err_o) ferr_cnt++;
            if (overrun_o) ovr_cnt++;
            if (busy_o) busy_cnt++;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        got_q.delete();
        ferr_cnt  = 0;
        ovr_cnt   = 0;
        vhigh_cnt = 0;
        busy_cnt  = 0;
    endtask

    function automatic int deff(input int d);
        return (d == 0) ? 1 : d;
    endfunction

    task automatic send_bit(input logic b, input int d);
        rx = b;
        cyc(16 * deff(d));
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input int d);
        div = 16'(d);
        send_bit(1'b0, d);
        for (int i = 0; i < 8; i++) send_bit(b[i], d);
        send_bit(stop, d);
    endtask

    typedef struct {
        int         d;
        logic [7:0] data;
        logic       stop;
        int         exp_n;
        logic [7:0] exp_data;
        int         exp_ferr;
        int         exp_busy;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{4, 8'hA5, 1'b1, 1, 8'hA5, 0, 152 * 4};
        vecs[1] = '{0, 8'h3C, 1'b1, 1, 8'h3C, 0, 152};
        vecs[2] = '{1, 8'hFF, 1'b1, 1, 8'hFF, 0, 152};
        vecs[3] = '{2, 8'h00, 1'b1, 1, 8'h00, 0, 152 * 2};
        vecs[4] = '{3, 8'h3C, 1'b0, 0, 8'h00, 1, 160 * 3};
        vecs[5] = '{5, 8'h55, 1'b1, 1, 8'h55, 0, 152 * 5};
        vecs[6] = '{4, 8'h80, 1'b1, 1, 8'h80, 0, 152 * 4};
        vecs[7] = '{1, 8'h01, 1'b1, 1, 8'h01, 0, 152};

        clear_mon();
        cyc(3);
        check("reset_valid", valid_o, 0);
        check("reset_data", data_o, 0);
        check("reset_busy", busy_o, 0);
        check("reset_ferr", frame_err_o, 0);
        check("reset_ovr", overrun_o, 0);
        rst = 1'b0;
        cyc(5);

        for (int v = 0; v < 8; v++) begin
            clear_mon();
            send_frame(vecs[v].data, vecs[v].stop, vecs[v].d);
            rx = 1'b1;
            cyc(32 * deff(vecs[v].d) + 10);
            check($sformatf("vec%0d_count", v), got_q.size(), vecs[v].exp_n);
            if (got_q.size() > 0)
                check($sformatf("vec%0d_data", v), got_q[0], vecs[v].exp_data);
            check($sformatf("vec%0d_vhigh", v), vhigh_cnt, vecs[v].exp_n);
            check($sformatf("vec%0d_ferr", v), ferr_cnt, vecs[v].exp_ferr);
            check($sformatf("vec%0d_ovr", v), ovr_cnt, 0);
            check($sformatf("vec%0d_busy_cycles", v), busy_cnt, vecs[v].exp_busy);
            check($sformatf("vec%0d_idle", v), busy_o, 0);
        end

        // glitch: 20-clk low pulse, start sample reads high
        clear_mon();
        div = 16'd4;
        rx = 1'b0;
        cyc(20);
        rx = 1'b1;
        cyc(100);
        check("glitch_count", got_q.size(), 0);
        check("glitch_ferr", ferr_cnt, 0);
        check("glitch_busy_cycles", busy_cnt, 32);
        check("glitch_idle", busy_o, 0);

        // framing error followed by a held-low break
        clear_mon();
        send_frame(8'h3C, 1'b0, 4);
        cyc(200);
        check("break_busy", busy_o, 1);
        check("break_ferr", ferr_cnt, 1);
        check("break_valid", valid_o, 0);
        rx = 1'b1;
        cyc(10);
        check("break_idle", busy_o, 0);
        check("break_busy_cycles", busy_cnt, 160 * 4 + 200);
        check("break_ferr_once", ferr_cnt, 1);
        clear_mon();
        send_frame(8'h55, 1'b1, 4);
        cyc(100);
        check("after_break_count", got_q.size(), 1);
        if (got_q.size() > 0) check("after_break_data", got_q[0], 8'h55);
        check("after_break_ferr", ferr_cnt, 0);

        // overrun: consumer stalled across two frames
        clear_mon();
        ready = 1'b0;
        send_frame(8'h11, 1'b1, 4);
        send_frame(8'h22, 1'b1, 4);
        cyc(50);
        check("ovr_valid", valid_o, 1);
        check("ovr_data", data_o, 8'h11);
        check("ovr_pulse", ovr_cnt, 1);
        check("ovr_ferr", ferr_cnt, 0);
        ready = 1'b1;
        cyc(1);
        ready = 1'b0;
        cyc(2);
        check("ovr_drain", valid_o, 0);

        // consume exactly in the second delivery cycle
        clear_mon();
        send_frame(8'h11, 1'b1, 4);
        fork
            send_frame(8'h22, 1'b1, 4);
            begin
                cyc(610);
                ready = 1'b1;
                cyc(1);
                ready = 1'b0;
            end
        join
        cyc(20);
        check("swap_count", got_q.size(), 1);
        if (got_q.size() > 0) check("swap_first", got_q[0], 8'h11);
        check("swap_valid", valid_o, 1);
        check("swap_data", data_o, 8'h22);
        check("swap_ovr", ovr_cnt, 0);
        ready = 1'b1;
        cyc(3);

        // disable after three data bits
        clear_mon();
        fork
            send_frame(8'h00, 1'b1, 4);
            begin
                cyc(236);
                rx_en = 1'b0;
                cyc(1);
                check("dis_busy_fall", busy_o, 0);
            end
        join
        rx = 1'b1;
        cyc(50);
        check("dis_count", got_q.size(), 0);
        check("dis_ferr", ferr_cnt, 0);
        check("dis_busy_cycles", busy_cnt, 234);
        rx_en = 1'b1;
        cyc(10);

        // async reset mid-frame with a byte held in the register
        ready = 1'b0;
        send_frame(8'h77, 1'b1, 4);
        cyc(20);
        check("pre_rst_valid", valid_o, 1);
        fork
            send_frame(8'h0F, 1'b1, 4);
            begin
                cyc(400);
                rst = 1'b1;
                #1;
                check("rst_valid", valid_o, 0);
                check("rst_data", data_o, 0);
                check("rst_busy", busy_o, 0);
                check("rst_ferr", frame_err_o, 0);
                cyc(2);
                rst = 1'b0;
                clear_mon();
            end
        join
        rx = 1'b1;
        cyc(20);
        check("rst_no_false_start", busy_cnt, 0);
        check("rst_no_byte", vhigh_cnt, 0);
        check("rst_no_ferr", ferr_cnt, 0);
        ready = 1'b1;
        clear_mon();
        send_frame(8'hC3, 1'b1, 4);
        cyc(100);
        check("post_rst_count", got_q.size(), 1);
        if (got_q.size() > 0) check("post_rst_data", got_q[0], 8'hC3);

        // randomized back-to-back traffic against a queue model
        clear_mon();
        exp_q.delete();
        begin
            int exp_ferr = 0;
            for (int f = 0; f < 40; f++) begin
                int         d   = $urandom_range(0, 5);
                logic [7:0] b   = 8'($urandom);
                logic       bad = ($urandom_range(0, 7) == 0);
                int         gap = $urandom_range(0, 2);
                send_frame(b, !bad, d);
                if (bad) begin
                    exp_ferr++;
                    if (gap == 0) gap = 1;
                end else begin
                    exp_q.push_back(b);
                end
                for (int g = 0; g < gap; g++) send_bit(1'b1, d);
            end
            rx = 1'b1;
            cyc(200);
            check("rand_count", got_q.size(), exp_q.size());
            for (int i = 0; i < exp_q.size(); i++) begin
                if (i < got_q.size())
                    check($sformatf("rand_byte%0d", i), got_q[i], exp_q[i]);
            end
            check("rand_ferr", ferr_cnt, exp_ferr);
            check("rand_ovr", ovr_cnt, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
